// File: rtl/filter_window_3x3_if.sv
// Pixel stream in, 3x3 window plus framing flags out.
interface filter_window_3x3_if #(
    parameter int unsigned PixelBit = 8
);
    logic                in_valid;
    logic                in_sof;
    logic [PixelBit-1:0] in_pixel;

    logic [PixelBit-1:0] pixel00;
    logic [PixelBit-1:0] pixel01;
    logic [PixelBit-1:0] pixel02;
    logic [PixelBit-1:0] pixel10;
    logic [PixelBit-1:0] pixel11;
    logic [PixelBit-1:0] pixel12;
    logic [PixelBit-1:0] pixel20;
    logic [PixelBit-1:0] pixel21;
    logic [PixelBit-1:0] pixel22;
    logic                win_valid;
    logic                win_sof;
    logic                win_eol;
    logic                win_eof;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  pixel00, pixel01, pixel02,
        input  pixel10, pixel11, pixel12,
        input  pixel20, pixel21, pixel22,
        input  win_valid, win_sof, win_eol, win_eof
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output pixel00, pixel01, pixel02,
        output pixel10, pixel11, pixel12,
        output pixel20, pixel21, pixel22,
        output win_valid, win_sof, win_eol, win_eof
    );
endinterface

// File: rtl/filter_window_3x3.sv
// 3x3 sliding window over a raster pixel stream, using two line buffers
// for the previous rows; flags complete in-image windows and frame edges.
module filter_window_3x3 #(
    parameter int unsigned PixelBit  = 8,
    parameter int unsigned ImgWidth  = 640,
    parameter int unsigned ImgHeight = 480
) (
    input logic                clk,
    input logic                rst_n,
    filter_window_3x3_if.slave bus
);
    localparam int unsigned ColW = $clog2(ImgWidth);
    localparam int unsigned RowW = $clog2(ImgHeight);

    typedef logic [PixelBit-1:0] pix_t;

    pix_t lb0 [ImgWidth];
    pix_t lb1 [ImgWidth];

    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;

    logic [ColW-1:0] pos_col_c;
    logic [RowW-1:0] pos_row_c;
    logic [ColW-1:0] col_nxt_c;
    logic [RowW-1:0] row_nxt_c;
    logic            last_col_c;
    logic            last_row_c;
    logic            valid_c;
    logic            sof_c;
    logic            eol_c;
    logic            eof_c;
    pix_t            lb0_rd_c;
    pix_t            lb1_rd_c;

    // Position of the pixel being accepted; in_sof forces (0,0).
    always_comb begin
        pos_col_c  = bus.in_sof ? '0 : col_q;
        pos_row_c  = bus.in_sof ? '0 : row_q;
        last_col_c = (pos_col_c == ColW'(ImgWidth - 1));
        last_row_c = (pos_row_c == RowW'(ImgHeight - 1));
        col_nxt_c  = pos_col_c + ColW'(1);
        row_nxt_c  = pos_row_c;
        if (last_col_c) begin
            col_nxt_c = '0;
            row_nxt_c = last_row_c ? '0 : pos_row_c + RowW'(1);
        end
        valid_c  = (pos_row_c >= RowW'(2)) && (pos_col_c >= ColW'(2));
        sof_c    = valid_c && (pos_row_c == RowW'(2)) && (pos_col_c == ColW'(2));
        eol_c    = valid_c && last_col_c;
        eof_c    = eol_c && last_row_c;
        lb0_rd_c = lb0[pos_col_c];
        lb1_rd_c = lb1[pos_col_c];
    end

    // Line buffers shift one row down per accepted pixel; contents are not reset.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb0[pos_col_c] <= lb1_rd_c;
            lb1[pos_col_c] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            bus.pixel00   <= '0;
            bus.pixel01   <= '0;
            bus.pixel02   <= '0;
            bus.pixel10   <= '0;
            bus.pixel11   <= '0;
            bus.pixel12   <= '0;
            bus.pixel20   <= '0;
            bus.pixel21   <= '0;
            bus.pixel22   <= '0;
            bus.win_valid <= 1'b0;
            bus.win_sof   <= 1'b0;
            bus.win_eol   <= 1'b0;
            bus.win_eof   <= 1'b0;
        end else begin
            bus.win_valid <= bus.in_valid && valid_c;
            bus.win_sof   <= bus.in_valid && sof_c;
            bus.win_eol   <= bus.in_valid && eol_c;
            bus.win_eof   <= bus.in_valid && eof_c;
            if (bus.in_valid) begin
                col_q       <= col_nxt_c;
                row_q       <= row_nxt_c;
                // Shift one column left; newest column enters at column 2.
                bus.pixel00 <= bus.pixel01;
                bus.pixel01 <= bus.pixel02;
                bus.pixel02 <= lb0_rd_c;
                bus.pixel10 <= bus.pixel11;
                bus.pixel11 <= bus.pixel12;
                bus.pixel12 <= lb1_rd_c;
                bus.pixel20 <= bus.pixel21;
                bus.pixel21 <= bus.pixel22;
                bus.pixel22 <= bus.in_pixel;
            end
        end
    end
endmodule

// File: tb/tb_filter_window_3x3.sv
// Scoreboard bench for filter_window_3x3 on an 8x6 image.
module tb_filter_window_3x3;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic [71:0] win;
        logic        valid;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    typedef struct packed {
        logic [71:0] win;
        logic        sof;
        logic        eol;
        logic        eof;
        int          idx;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    filter_window_3x3_if #(.PixelBit(8)) bus ();

    filter_window_3x3 #(
        .PixelBit (8),
        .ImgWidth (W),
        .ImgHeight(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t       exp_q[$];
    obs_t       obs_q[$];
    int         n_vec;
    int         n_err;
    int         acc_cnt;
    int         mr;
    int         mc;
    logic [7:0] img[H][W];

    function automatic logic [71:0] cur_win();
        return {bus.pixel00, bus.pixel01, bus.pixel02,
                bus.pixel10, bus.pixel11, bus.pixel12,
                bus.pixel20, bus.pixel21, bus.pixel22};
    endfunction

    function automatic logic [3:0] cur_flags();
        return {bus.win_valid, bus.win_sof, bus.win_eol, bus.win_eof};
    endfunction

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Drive one accepted pixel and queue the window the image model predicts.
    task automatic send(input logic [7:0] px, input logic sof);
        exp_t        e;
        logic [71:0] w;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = px;
        e.valid = (mr >= 2) && (mc >= 2);
        w = '0;
        if (e.valid) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w = {w[63:0], img[mr-2+i][mc-2+j]};
        end else begin
            w = {64'h0, px};
        end
        e.win = w;
        e.sof = e.valid && (mr == 2) && (mc == 2);
        e.eol = e.valid && (mc == W - 1);
        e.eof = e.eol && (mr == H - 1);
        exp_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = px;
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic idle(input int n, input logic noisy_sof);
        repeat (n) begin
            bus.in_valid = 1'b0;
            bus.in_sof   = noisy_sof;
            @(posedge clk);
            #3;
        end
        bus.in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] orv, input int idle_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while (int'($urandom_range(99)) < idle_pct) idle(1, 1'($urandom_range(1)));
                send(8'(r * 16 + c) | orv, 1'b0);
            end
    endtask

    // Hand-derived checks on the windows of one frame (accepts base..base+47).
    task automatic check_frame(input int base, input logic [7:0] orv, input string tag);
        int          nv;
        int          neol;
        int          nsof;
        int          first;
        obs_t        last;
        logic [71:0] o;
        nv    = 0;
        neol  = 0;
        nsof  = 0;
        first = -1;
        last  = '0;
        o     = {9{orv}};
        foreach (obs_q[k]) begin
            if (obs_q[k].idx >= base && obs_q[k].idx < base + W * H) begin
                nv++;
                if (obs_q[k].eol) neol++;
                if (obs_q[k].sof) nsof++;
                if (first < 0) first = k;
                last = obs_q[k];
            end
        end
        chk({tag, "_valid_count"}, 72'(nv), 72'(24));
        chk({tag, "_eol_count"}, 72'(neol), 72'(4));
        chk({tag, "_sof_count"}, 72'(nsof), 72'(1));
        if (first >= 0) begin
            chk({tag, "_first_pos"}, 72'(obs_q[first].idx - base), 72'(18));
            chk({tag, "_first_sof"}, 72'(obs_q[first].sof), 72'(1));
            chk({tag, "_first_diag"},
                72'({obs_q[first].win[71:64], obs_q[first].win[39:32], obs_q[first].win[7:0]}),
                72'({8'h00 | orv, 8'h11 | orv, 8'h22 | orv}));
            chk({tag, "_last_eof"}, 72'(last.eof), 72'(1));
            chk({tag, "_last_win"}, last.win, 72'h35_36_37_45_46_47_55_56_57 | o);
        end
    endtask

    // Monitor: pops one expectation per accepted pixel; idle cycles must hold.
    task automatic monitor();
        logic [71:0] prev;
        logic [71:0] cw;
        logic [3:0]  fl;
        logic        acc;
        exp_t        e;
        prev = '0;
        forever begin
            @(posedge clk);
            acc = bus.in_valid && rst_n;
            @(negedge clk);
            cw = cur_win();
            fl = cur_flags();
            if (rst_n && acc) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard_underflow: got output, expected none queued");
                end else begin
                    e = exp_q.pop_front();
                    chk("flags", 72'(fl), 72'({e.valid, e.sof, e.eol, e.eof}));
                    if (e.valid) chk("window", cw, e.win);
                    else         chk("pixel22", 72'(bus.pixel22), e.win);
                end
                if (bus.win_valid)
                    obs_q.push_back('{win: cw, sof: bus.win_sof, eol: bus.win_eol,
                                      eof: bus.win_eof, idx: acc_cnt});
                acc_cnt++;
            end else if (rst_n) begin
                chk("idle_flags", 72'(fl), 72'(0));
                chk("idle_hold", cw, prev);
            end
            prev = cw;
        end
    endtask

    initial begin
        int base;
        int z;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        rst_n   = 1'b0;
        n_vec   = 0;
        n_err   = 0;
        acc_cnt = 0;
        mr      = 0;
        mc      = 0;
        fork
            monitor();
        join_none

        #1;
        chk("reset_window", cur_win(), 72'(0));
        chk("reset_flags", 72'(cur_flags()), 72'(0));
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Contiguous frame
        base = acc_cnt;
        send_frame(8'h00, 0);
        idle(2, 1'b0);
        check_frame(base, 8'h00, "s1");

        // Same frame with idle gaps (in_sof toggling while in_valid=0)
        base = acc_cnt;
        send_frame(8'h00, 40);
        idle(2, 1'b0);
        check_frame(base, 8'h00, "s2");

        // in_sof restart at old (3,4)
        for (int k = 0; k < 3 * W + 4; k++) send(8'((k / W) * 16 + (k % W)), 1'b0);
        idle(2, 1'b0);
        base = acc_cnt;
        send(8'h00, 1'b1);
        for (int k = 1; k < W * H; k++) send(8'((k / W) * 16 + (k % W)), 1'b0);
        idle(2, 1'b0);
        check_frame(base, 8'h00, "s3");

        // Back-to-back frames, second frame tagged with bit 7
        base = acc_cnt;
        send_frame(8'h00, 0);
        send_frame(8'h80, 0);
        idle(2, 1'b0);
        check_frame(base, 8'h00, "s4a");
        check_frame(base + W * H, 8'h80, "s4b");

        // Reset while the (3,3) window is being presented
        for (int k = 0; k < 3 * W + 4; k++) send(8'((k / W) * 16 + (k % W)), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_window", cur_win(), 72'(0));
        chk("midreset_flags", 72'(cur_flags()), 72'(0));
        mr = 0;
        mc = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2, 1'b0);
        base = acc_cnt;
        send_frame(8'h00, 0);
        idle(2, 1'b0);
        check_frame(base, 8'h00, "s5");

        // Single dark pixel at (3,3) in a white frame
        base = acc_cnt;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send((r == 3 && c == 3) ? 8'h00 : 8'hFF, 1'b0);
        idle(2, 1'b0);
        z = -1;
        foreach (obs_q[k])
            if (z < 0 && obs_q[k].idx >= base && obs_q[k].win[7:0] == 8'h00) z = k;
        chk("s6_dark_pos", 72'((z < 0) ? -1 : obs_q[z].idx - base), 72'(27));
        if (z >= 0 && z + 2 < obs_q.size()) begin
            chk("s6_dark_at_22", obs_q[z].win,     72'hFF_FF_FF_FF_FF_FF_FF_FF_00);
            chk("s6_dark_at_21", obs_q[z + 1].win, 72'hFF_FF_FF_FF_FF_FF_FF_00_FF);
            chk("s6_dark_at_20", obs_q[z + 2].win, 72'hFF_FF_FF_FF_FF_FF_00_FF_FF);
        end

        chk("scoreboard_drain", 72'(exp_q.size()), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
